// File: rtl/dpram_pkg.sv
// Shared sizing constants for the dual-port-RAM FIFO controller and its RAM.
package dpram_pkg;
    localparam int DW       = 8;
    localparam int AW       = 8;
    localparam int DEPTH    = 1 << AW;
    localparam int AF_LEVEL = 240;
endpackage

// File: rtl/dprams.sv
// Simple dual-port RAM: one write port, one read port with a registered q.
module dprams #(
    parameter int DW = dpram_pkg::DW,
    parameter int AW = dpram_pkg::AW
) (
    input  logic          clock,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] wraddress,
    input  logic [AW-1:0] rdaddress,
    input  logic          wren,
    output logic [DW-1:0] q
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clock) begin
        if (wren)
            mem[wraddress] <= data;
        q <= mem[rdaddress];
    end
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller around dprams: count-based flags, 1-cycle read latency,
// one-cycle overflow/underflow pulses, synchronous flush.
module dpram_fifo_ctrl #(
    parameter int DW       = dpram_pkg::DW,
    parameter int AW       = dpram_pkg::AW,
    parameter int AF_LEVEL = dpram_pkg::AF_LEVEL
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          flush,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);
    localparam int          DEPTH  = 1 << AW;
    localparam logic [AW:0] FULL_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C   = AF_LEVEL[AW:0];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_acc, rd_acc;
    logic [AW:0]   cnt_nxt;
    logic [DW-1:0] ram_q;

    // Gating uses the registered flags, so a read and write can never
    // hit the same address in one cycle.
    assign wr_acc  = wr_en & ~full  & ~flush;
    assign rd_acc  = rd_en & ~empty & ~flush;
    assign cnt_nxt = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count       <= cnt_nxt;
            full        <= (cnt_nxt == FULL_C);
            empty       <= (cnt_nxt == '0);
            almost_full <= (cnt_nxt >= AF_C);
            rd_valid    <= rd_acc;
            overflow    <= wr_en & full;
            underflow   <= rd_en & empty;
        end
    end

    // RAM q is not resettable; mask it so rd_data reads zero when idle.
    assign rd_data = rd_valid ? ram_q : '0;

    dprams #(.DW(DW), .AW(AW)) u_ram (
        .clock     (clk),
        .data      (wr_data),
        .wraddress (wr_ptr),
        .rdaddress (rd_ptr),
        .wren      (wr_acc),
        .q         (ram_q)
    );
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed-vector bench for dpram_fifo_ctrl with hand-computed expectations.
module tb_dpram_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en, flush;
    logic [DW-1:0] wr_data, rd_data;
    logic          rd_valid, full, empty, almost_full, overflow, underflow;
    logic [AW:0]   count;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DW(DW), .AW(AW), .AF_LEVEL(240)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .flush(flush), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        idle();
        wr_data = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_rvld", rd_valid, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);

        // write order
        for (int i = 0; i < 16; i++) push(8'(255 - i));
        chk("wo_count16", count, 16);
        chk("wo_notempty", empty, 0);
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            chk("wo_rvld", rd_valid, 1);
            chk("wo_rdata", rd_data, 255 - i);
            chk("wo_count", count, 15 - i);
        end
        rd_en = 1'b0;
        tick();
        chk("wo_rvld_end", rd_valid, 0);
        chk("wo_empty_end", empty, 1);

        // almost-full / full boundary; pointers start at 16 here
        for (int i = 0; i < 239; i++) push(8'(i));
        chk("af_239", almost_full, 0);
        chk("cnt_239", count, 239);
        push(8'd239);
        chk("af_240", almost_full, 1);
        for (int i = 240; i < 256; i++) push(8'(i));
        chk("full_256", full, 1);
        chk("cnt_256", count, 256);
        chk("full_noovf", overflow, 0);
        wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        chk("ovf_pulse", overflow, 1);
        chk("ovf_cnt", count, 256);
        wr_en = 1'b0;
        tick();
        chk("ovf_clear", overflow, 0);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
        tick();
        chk("fullrw_cnt", count, 255);
        chk("fullrw_full", full, 0);
        chk("fullrw_ovf", overflow, 1);
        chk("fullrw_rvld", rd_valid, 1);
        chk("fullrw_rdata", rd_data, 0);
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_cnt", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_rvld", rd_valid, 0);

        // empty boundary
        rd_en = 1'b1;
        tick();
        chk("unf_pulse", underflow, 1);
        chk("unf_rvld", rd_valid, 0);
        rd_en = 1'b0;
        tick();
        chk("unf_clear", underflow, 0);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hA5;
        tick();
        chk("emprw_cnt", count, 1);
        chk("emprw_rvld", rd_valid, 0);
        chk("emprw_unf", underflow, 1);
        wr_en = 1'b0;
        tick();
        chk("emprw_rdata", rd_data, 8'hA5);
        chk("emprw_cnt0", count, 0);
        rd_en = 1'b0;

        // wrap: 300 words, reads trailing by 4
        flush = 1'b1; tick(); flush = 1'b0;
        for (int c = 0; c < 304; c++) begin
            wr_en   = (c < 300);
            wr_data = 8'(c);
            rd_en   = (c >= 4);
            tick();
            if (c >= 4) begin
                chk("wrap_rvld", rd_valid, 1);
                chk("wrap_rdata", rd_data, (c - 4) % 256);
            end
        end
        idle();
        tick();
        chk("wrap_empty", empty, 1);
        chk("wrap_cnt", count, 0);

        // reset mid-operation
        for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
        chk("mr_cnt10", count, 10);
        rd_en = 1'b1;
        tick();
        chk("mr_rvld", rd_valid, 1);
        chk("mr_rdata", rd_data, 8'h10);
        rd_en = 1'b1; rst = 1'b1; flush = 1'b1;
        tick();
        idle();
        chk("mr_cnt", count, 0);
        chk("mr_empty", empty, 1);
        chk("mr_rvld0", rd_valid, 0);
        chk("mr_rdata0", rd_data, 0);
        push(8'h3C);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("mr_fresh", rd_data, 8'h3C);
        chk("mr_fresh_v", rd_valid, 1);

        // flush mid-operation, with same-cycle requests ignored
        for (int i = 0; i < 10; i++) push(8'(8'h50 + i));
        rd_en = 1'b1;
        tick();
        chk("mf_rdata", rd_data, 8'h50);
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'hFF; flush = 1'b1;
        tick();
        idle();
        chk("mf_cnt", count, 0);
        chk("mf_empty", empty, 1);
        chk("mf_rvld0", rd_valid, 0);
        push(8'hC3);
        chk("mf_cnt1", count, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("mf_fresh", rd_data, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DW, 8, data width.
- AW, 8, address width; depth = 2^AW = 256.
- AF_LEVEL, 240, almost_full threshold in words.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DW  write data.
- rd_en  in  1  read request.
- flush  in  1  synchronous clear of FIFO state.
- rd_data  out  DW  read data; meaningful only while rd_valid=1.
- rd_valid  out  1  rd_data holds an accepted read's word.
- full  out  1  count == 2^AW.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  AW+1  stored word count, 0..2^AW.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.
REQ-003 The design SHALL use one clock, clk; reset SHALL be rst, synchronous and active-high.

Function
REQ-004 A write SHALL be accepted when wr_en=1 and full=0; accepted writes drive wren=1, wraddress=wr_ptr and data=wr_data to the RAM in the same cycle, and wr_ptr increments modulo 2^AW.
REQ-005 A read SHALL be accepted when rd_en=1 and empty=0; accepted reads drive rdaddress=rd_ptr, and rd_ptr increments modulo 2^AW.
REQ-006 RAM read latency SHALL be 1 clock: rd_valid=1 and rd_data=RAM q in the cycle after acceptance; rd_valid=0 otherwise.
REQ-007 full, empty, almost_full and count SHALL be registered, and SHALL reflect all accepts from the previous edge.
REQ-008 Gating SHALL use the registered flags at the edge:
- wr_en=1 and rd_en=1 while full: read accepted, write rejected, count -1.
- wr_en=1 and rd_en=1 while empty: write accepted, read rejected, count +1.
- Both accepted otherwise: count unchanged.
REQ-009 overflow SHALL pulse for 1 cycle per rejected write; underflow SHALL pulse for 1 cycle per rejected read; neither is sticky.
REQ-010 Pointer wrap 255->0 SHALL be seamless; full/empty SHALL be derived from count, never from pointer equality alone.
REQ-011 flush=1 SHALL, at the next edge, zero pointers and count, set empty=1, clear rd_valid, and ignore same-cycle wr_en/rd_en; RAM contents are untouched.
REQ-012 A read and a write SHALL never target the same address in one cycle; REQ-004/005 gating guarantees this, so no bypass logic is required.

Reset
REQ-013 On rst=1 at an edge, all of the following SHALL clear: wr_ptr, rd_ptr, count, rd_valid, rd_data, full, almost_full, overflow and underflow.
REQ-014 On the same edge, empty SHALL be set to 1.
REQ-015 Reset mid-operation SHALL discard stored words and any in-flight read, with no rd_valid pulse after rst.
REQ-016 rst SHALL take priority over flush and over all requests; RAM contents are not cleared.

Structure
REQ-017 DW, AW and the default AF_LEVEL SHALL live in shared package dpram_pkg, together with the depth constant 2^AW.
REQ-018 The block SHALL instantiate exactly one sub-module, dprams, connecting clock=clk, data, wraddress, rdaddress, wren and q.
REQ-019 The controller SHALL NOT add an output register beyond dprams' 1-cycle read path.

Verification
REQ-020 The bench SHALL cover the following scenarios:
- Write order: after reset, write 16 words 255-i at addr i, then issue 16 reads -> rd_data 255..240 in order, each 1 cycle after rd_en, with count 16->0 and empty=1 at the end.
- Full boundary: write 256 words -> full=1 and count=256; a 257th write -> overflow pulse, count stays 256; simultaneous rd+wr while full -> count=255.
- Empty boundary: rd_en on an empty FIFO -> underflow pulse and rd_valid=0; simultaneous rd+wr while empty -> count=1, no rd_valid.
- Wrap: stream 300 words, value i mod 256, with reads trailing by 4 -> all 300 read back in order across the pointer wrap.
- Almost-full: write 239 words -> almost_full=0; one more write -> almost_full=1.
- Reset/flush mid-operation: count=10 with a read accepted, then rst (or flush) -> next cycle count=0, empty=1, rd_valid=0; a fresh write/read returns the new data.
